// File: rtl/counter_seq_monitor_if.sv
// ---------------------------------------------------------------------------
// counter_seq_monitor_if
//   Groups the monitored counter bus with the monitor's status outputs.
//
//   Parameters:
//     WIDTH      width of the monitored counter bus
//
//   Signals:
//     counter    monitored counter value (driven by the counter side)
//     locked     level: sequence tracked and consistent
//     error      one-cycle pulse per detected step violation
//     fault      level: violation seen since last lock/reset
//     err_count  saturating 8-bit violation tally
//
//   Modports:
//     master     counter side: drives counter, observes status
//     slave      monitor side: samples counter, drives status
// ---------------------------------------------------------------------------
interface counter_seq_monitor_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] counter;
    logic             locked;
    logic             error;
    logic             fault;
    logic [7:0]       err_count;

    modport master (
        output counter,
        input  locked,
        input  error,
        input  fault,
        input  err_count
    );

    modport slave (
        input  counter,
        output locked,
        output error,
        output fault,
        output err_count
    );
endinterface

// File: rtl/counter_seq_monitor.sv
// ---------------------------------------------------------------------------
// counter_seq_monitor
//   Sampling-side checker for a free-running binary counter. Every rising
//   edge the counter bus is compared with (previous sample + 1) mod 2^WIDTH.
//   The monitor acquires lock after LOCK_CNT consecutive correct steps,
//   pulses error for each step violation while locked, and keeps an 8-bit
//   saturating violation tally.
//
//   Parameters:
//     WIDTH     width of the monitored counter bus (default 4)
//     LOCK_CNT  consecutive correct steps needed for lock, 1..15 (default 2)
//
//   Ports:
//     clk       rising-edge clock shared with the monitored counter
//     reset     synchronous, active-high reset
//     bus       counter_seq_monitor_if.slave (counter in; locked, error,
//               fault, err_count out; all outputs registered)
//
//   Build option:
//     COUNTER_SEQ_MONITOR_STICKY_EN
//       defined   : a violation while locked moves to a terminal FAULT state;
//                   fault latches until reset and every later mismatch is
//                   counted.
//       undefined : a violation while locked drops back to acquisition;
//                   fault clears when lock is regained and mismatches during
//                   acquisition are not counted.
// ---------------------------------------------------------------------------
module counter_seq_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_seq_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
        ,
        S_FAULT   = 2'd3
`endif
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] prev_q;
    logic [3:0]       streak_q, streak_n;
    logic             locked_q, locked_n;
    logic             error_q, error_n;
    logic             fault_q, fault_n;
    logic [7:0]       err_count_q, err_count_n;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic [3:0]       streak_inc;
    logic [7:0]       err_count_sat;

    // Truncation to WIDTH makes the all-ones -> zero wrap a legal step.
    assign expected      = prev_q + WIDTH'(1);
    assign match         = (bus.counter == expected);
    // streak never exceeds LOCK_CNT-1 (<= 14) while acquiring, so no overflow.
    assign streak_inc    = streak_q + 4'd1;
    assign err_count_sat = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state_q;
        streak_n    = streak_q;
        locked_n    = locked_q;
        error_n     = 1'b0;
        fault_n     = fault_q;
        err_count_n = err_count_q;

        case (state_q)
            S_IDLE: begin
                // First edge out of reset only captures a reference sample.
                streak_n = '0;
                state_n  = S_ACQUIRE;
            end

            S_ACQUIRE: begin
                if (match) begin
                    if (streak_inc == LOCK_TGT) begin
                        state_n  = S_LOCKED;
                        locked_n = 1'b1;
                        fault_n  = 1'b0;
                        streak_n = '0;
                    end else begin
                        streak_n = streak_inc;
                    end
                end else begin
                    // Unlocked mismatches restart acquisition silently.
                    streak_n = '0;
                end
            end

            S_LOCKED: begin
                if (!match) begin
                    error_n     = 1'b1;
                    err_count_n = err_count_sat;
                    fault_n     = 1'b1;
                    locked_n    = 1'b0;
                    streak_n    = '0;
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
                    state_n     = S_FAULT;
`else
                    state_n     = S_ACQUIRE;
`endif
                end
            end

`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
            S_FAULT: begin
                // Terminal until reset: keep checking and counting.
                if (!match) begin
                    error_n     = 1'b1;
                    err_count_n = err_count_sat;
                end
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            streak_q    <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            fault_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_n;
            prev_q      <= bus.counter;
            streak_q    <= streak_n;
            locked_q    <= locked_n;
            error_q     <= error_n;
            fault_q     <= fault_n;
            err_count_q <= err_count_n;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.error     = error_q;
    assign bus.fault     = fault_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_counter_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_monitor
//   Self-checking bench for counter_seq_monitor (WIDTH=4, LOCK_CNT=2).
//   Directed vector table, a saturation sequence, and randomized stimulus
//   checked against a history-based reference model. Honors
//   COUNTER_SEQ_MONITOR_STICKY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_counter_seq_monitor;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int MODULUS  = 1 << WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    counter_seq_monitor_if #(.WIDTH(WIDTH)) bus ();

    counter_seq_monitor #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model. Works from the sample history rather than a state
    // machine: 'run' is the number of consecutive correct +1 steps ending at
    // the latest sample; lock means run >= LOCK_CNT (and, in the sticky
    // build, no violation since reset). A violation is a bad step taken while
    // locked (sticky: at any time after first lock).
    // -----------------------------------------------------------------------
    bit m_have;
    int m_prev;
    int m_run;
    int m_nerr;
    bit m_ever;
    bit m_locked, m_error, m_fault;

    function automatic int m_count();
        return (m_nerr > 255) ? 255 : m_nerr;
    endfunction

    function automatic void model_update(input bit r, input int v);
        bit good;
        bit was_locked;
        if (r) begin
            m_have = 0; m_prev = 0; m_run = 0; m_nerr = 0; m_ever = 0;
            m_locked = 0; m_error = 0; m_fault = 0;
            return;
        end
        if (!m_have) begin
            m_have  = 1;
            m_prev  = v;
            m_run   = 0;
            m_error = 0;
            return;
        end
        good       = (v == (m_prev + 1) % MODULUS);
        was_locked = m_locked;
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
        m_error = !good && m_ever;
`else
        m_error = !good && was_locked;
`endif
        if (m_error) m_nerr++;
        m_run = good ? m_run + 1 : 0;
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
        m_locked = (m_run >= LOCK_CNT) && (m_nerr == 0);
        m_fault  = (m_nerr > 0);
`else
        m_locked = (m_run >= LOCK_CNT);
        m_fault  = (m_nerr > 0) && !m_locked;
`endif
        m_ever = m_ever || m_locked;
        m_prev = v;
    endfunction

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input bit r, input int v);
        @(negedge clk);
        reset       = r;
        bus.counter = 4'(v % MODULUS);
        @(posedge clk);
        #1;
        model_update(r, v % MODULUS);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".locked"},    32'(bus.locked),    32'(m_locked));
        check({tag, ".error"},     32'(bus.error),     32'(m_error));
        check({tag, ".fault"},     32'(bus.fault),     32'(m_fault));
        check({tag, ".err_count"}, 32'(bus.err_count), 32'(m_count()));
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        bit   rst;
        int   cnt;
        bit   exp_locked;
        bit   exp_error;
        bit   exp_fault;
        int   exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input int c, input bit l,
                                input bit e, input bit f, input int n);
        vec_t x;
        x.rst = r; x.cnt = c; x.exp_locked = l;
        x.exp_error = e; x.exp_fault = f; x.exp_count = n;
        return x;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int v;
        bit r;

        bus.counter = '0;

        // Lock-in from reset: capture 0, lock on sample 2.
        vecs.push_back(mk(1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0,  3, 1, 0, 0, 0));
        // Wrap while locked: 14,15,0,1.
        vecs.push_back(mk(1, 12, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0));
        vecs.push_back(mk(0, 14, 1, 0, 0, 0));
        vecs.push_back(mk(0, 15, 1, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0,  1, 1, 0, 0, 0));
        // Skip: locked at 5, then 7.
        vecs.push_back(mk(0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0,  3, 1, 0, 0, 0));
        vecs.push_back(mk(0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0,  7, 0, 1, 1, 1));
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
        vecs.push_back(mk(0,  8, 0, 0, 1, 1));
        vecs.push_back(mk(0,  9, 0, 0, 1, 1));
        vecs.push_back(mk(0,  9, 0, 1, 1, 2));
        vecs.push_back(mk(0, 10, 0, 0, 1, 2));
        vecs.push_back(mk(0, 11, 0, 0, 1, 2));
`else
        vecs.push_back(mk(0,  8, 0, 0, 1, 1));
        vecs.push_back(mk(0,  9, 1, 0, 0, 1));
        vecs.push_back(mk(0,  9, 0, 1, 1, 2));
        vecs.push_back(mk(0, 10, 0, 0, 1, 2));
        vecs.push_back(mk(0, 11, 1, 0, 0, 2));
`endif
        vecs.push_back(mk(0, 11, 0, 1, 1, 3));
        // Reset mid-operation with err_count=3, then relock.
        vecs.push_back(mk(1,  5, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  2, 1, 0, 0, 0));
        // Hold: locked at 5, then 5 again; error lasts one cycle.
        vecs.push_back(mk(1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  3, 0, 0, 0, 0));
        vecs.push_back(mk(0,  4, 0, 0, 0, 0));
        vecs.push_back(mk(0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0,  5, 0, 1, 1, 1));
        vecs.push_back(mk(0,  6, 0, 0, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cnt);
            check($sformatf("vec%0d.locked", i),    32'(bus.locked),    32'(vecs[i].exp_locked));
            check($sformatf("vec%0d.error", i),     32'(bus.error),     32'(vecs[i].exp_error));
            check($sformatf("vec%0d.fault", i),     32'(bus.fault),     32'(vecs[i].exp_fault));
            check($sformatf("vec%0d.err_count", i), 32'(bus.err_count), 32'(vecs[i].exp_count));
        end

        // -------------------------------------------------------------------
        // Saturation of err_count.
        // -------------------------------------------------------------------
        drive(1, 0);
        drive(0, 0);
        drive(0, 1);
        drive(0, 2);
        check_model("sat_lock");
`ifdef COUNTER_SEQ_MONITOR_STICKY_EN
        // Constant 0 forever: every edge is a violation in FAULT.
        for (int i = 0; i < 300; i++) begin
            drive(0, 0);
            check($sformatf("sat%0d.error", i), 32'(bus.error), 32'd1);
            check_model($sformatf("sat%0d", i));
        end
`else
        // Break and regain lock repeatedly: one counted violation per round.
        v = 2;
        for (int i = 0; i < 300; i++) begin
            v = (v + 2) % MODULUS;
            drive(0, v);
            check($sformatf("sat%0d.error", i), 32'(bus.error), 32'd1);
            check_model($sformatf("sat%0d", i));
            v = (v + 1) % MODULUS;
            drive(0, v);
            v = (v + 1) % MODULUS;
            drive(0, v);
            check_model($sformatf("sat%0d_relock", i));
        end
`endif
        check("sat_final.err_count", 32'(bus.err_count), 32'd255);

        // -------------------------------------------------------------------
        // Randomized stimulus against the reference model.
        // -------------------------------------------------------------------
        drive(1, 0);
        check_model("rnd_reset");
        v = int'($urandom_range(0, MODULUS - 1));
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 19))
                0:       v = int'($urandom_range(0, MODULUS - 1));
                1:       v = v;
                default: v = (v + 1) % MODULUS;
            endcase
            drive(r, v);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_seq_monitor.md
# counter_seq_monitor

Sampling-side checker for the free-running binary counter bus. Samples the counter output on every rising clock edge and verifies the sequence advances by exactly +1 modulo 2^WIDTH. It acquires lock on the sequence, flags each step violation with a one-cycle pulse, and keeps a saturating error tally. It sits beside the counter in synthesized/NAND-mapped regressions as a self-checking monitor and can also be instantiated in silicon as a health flag.

## Interface
- WIDTH, 4, width of the monitored counter bus
- LOCK_CNT, 2, consecutive correct +1 steps required to declare lock; legal range 1..15
- clk  input  1  rising-edge clock, shared with the monitored counter
- reset  input  1  synchronous, active-high; one clock, synchronous reset
- counter  input  WIDTH  monitored counter value, sampled each rising edge
- locked  output  1  level; sequence tracked and consistent
- error  output  1  one-cycle pulse per detected step violation
- fault  output  1  level; a violation has occurred since last lock/reset
- err_count  output  8  saturating count of violations

## Operation
- Registers: `prev` (WIDTH), `streak` (4 bits), 2-bit state, outputs registered.
- `expected` = (`prev` + 1) truncated to WIDTH bits; 2^WIDTH−1 → 0 is a legal step.
- `match` = (`counter` == `expected`). A held value or any skip is a mismatch.
- `prev` <= `counter` on every non-reset edge, in every state.
- States:
  - IDLE: entered on reset. Next edge: capture `counter`, `streak`=0, go ACQUIRE. No checking.
  - ACQUIRE: match → `streak`+1; when the incremented value equals LOCK_CNT → LOCKED, `locked`=1, `fault`=0 (non-sticky build). Mismatch → `streak`=0, no error, no count.
  - LOCKED: match → stay. Mismatch → `error`=1 for one cycle, `err_count`+1 (saturating at 255), `fault`=1, `locked`=0; next state per Configuration.
  - FAULT (sticky build only): keeps comparing; each mismatch pulses `error` and increments `err_count`; `locked` stays 0; leaves only on reset.
- `err_count` never wraps; at 255 further mismatches still pulse `error`.

## Timing
- Reset values: `locked`=0, `error`=0, `fault`=0, `err_count`=0, `prev`=0, `streak`=0, state IDLE.
- Reset has priority over every other event; asserted mid-lock or mid-fault, all outputs read reset values after that edge.
- First edge with reset low: capture only. With LOCK_CNT=2 and a correct counter, `locked` is high after the 3rd post-reset edge.
- Violation latency: `error`, `fault` set and `locked` cleared in the same edge that samples the bad value, visible for exactly one clock (`error`) / until cleared (`fault`).
- `err_count` updates on the same edge as `error`.
- Back-to-back mismatches in FAULT produce back-to-back `error` pulses (continuous high).

## Configuration
- `COUNTER_SEQ_MONITOR_STICKY_EN` defined: mismatch in LOCKED → FAULT; `fault` latched until reset; all later mismatches counted.
- Not defined: mismatch in LOCKED → ACQUIRE with `streak`=0; `fault` stays 1 until lock is regained, then clears; mismatches during ACQUIRE are not counted. FAULT state is not built.

## Test plan
- Lock-in: reset 1 cycle, drive 0,1,2,3 one per edge (LOCK_CNT=2) → `locked`=1 after sample 2, `error` never asserted, `err_count`=0.
- Wrap: locked, drive 14,15,0,1 → no `error`, `locked` stays 1.
- Skip: locked at 5, drive 7 → `error` high exactly one cycle, `err_count`=1, `fault`=1, `locked`=0; non-sticky: drive 8,9 → `locked`=1, `fault`=0.
- Hold: locked at 5, drive 5 again → `error` pulse, `err_count`=1.
- Reset mid-operation: locked with `err_count`=3, assert reset one edge → all outputs 0; release and drive 0,1,2 → relock.
- Saturation (sticky build): after lock, drive constant 0 for 300 edges → `error` continuously high, `err_count`=255, `fault`=1, `locked`=0.
